// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// over a shared memory with a ready handshake and a wait-state timeout.
//
// state  | meaning
// 0      | FETCH   read instruction at PC, PC+4
// 1      | DECODE  branch target precompute, dispatch on opcode
// 2      | MEMADR  effective address for LW/SW
// 3      | MEMRD   data read
// 4      | MEMWB   load writeback
// 5      | MEMWR   data write
// 6      | RTEXEC  R-type ALU op
// 7      | RTWB    R-type writeback to rd
// 8      | BRANCH  BEQ/BNE compare and PC update
// 9      | IEXEC   immediate ALU op
// 10     | IWB     immediate writeback to rt
// 11     | JUMP    J/JAL/JR
// 15     | FAULT   absorbing until reset
module mips_multicycle_ctrl #(
  parameter int USE_MEM_READY = 1,
  parameter int MEM_TIMEOUT   = 15,
  parameter int ENABLE_JAL    = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Func,
  input  logic       Zero,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic [1:0] MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] PCSrc,
  output logic [3:0] ALUControl,
  output logic [3:0] state_o,
  output logic       fault
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_RTEXEC = 4'd6;
  localparam logic [3:0] S_RTWB   = 4'd7;
  localparam logic [3:0] S_BRANCH = 4'd8;
  localparam logic [3:0] S_IEXEC  = 4'd9;
  localparam logic [3:0] S_IWB    = 4'd10;
  localparam logic [3:0] S_JUMP   = 4'd11;
  localparam logic [3:0] S_FAULT  = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] F_JR     = 6'b001000;

  localparam logic [3:0] A_ADD  = 4'b0000;
  localparam logic [3:0] A_SUB  = 4'b0001;
  localparam logic [3:0] A_AND  = 4'b0010;
  localparam logic [3:0] A_OR   = 4'b0011;
  localparam logic [3:0] A_XOR  = 4'b0100;
  localparam logic [3:0] A_SLL  = 4'b0101;
  localparam logic [3:0] A_SRL  = 4'b0110;
  localparam logic [3:0] A_SRA  = 4'b0111;
  localparam logic [3:0] A_SLT  = 4'b1000;
  localparam logic [3:0] A_SLTU = 4'b1001;
  localparam logic [3:0] A_NOR  = 4'b1010;
  localparam logic [3:0] A_SLLV = 4'b1011;
  localparam logic [3:0] A_SRLV = 4'b1100;
  localparam logic [3:0] A_SRAV = 4'b1101;
  localparam logic [3:0] A_LUI  = 4'b1110;

  localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

  logic [3:0] state, state_next;
  logic [7:0] wait_cnt;
  logic       rdy, mem_state, timed_out, is_jr, jal_ok, r_ok;
  logic [3:0] r_alu, i_alu;

  assign rdy       = (USE_MEM_READY == 0) ? 1'b1 : mem_ready;
  assign mem_state = (state == S_FETCH) || (state == S_MEMRD) || (state == S_MEMWR);
  // ready wins over timeout when both land in the same cycle
  assign timed_out = mem_state && !rdy && (wait_cnt == TIMEOUT);
  assign is_jr     = (Opcode == OP_RTYPE) && (Func == F_JR);
  assign jal_ok    = (ENABLE_JAL != 0);
  assign state_o   = state;

  always_comb begin
    r_ok  = 1'b1;
    r_alu = A_ADD;
    case (Func)
      6'b100000, 6'b100001: r_alu = A_ADD;
      6'b100010, 6'b100011: r_alu = A_SUB;
      6'b100100: r_alu = A_AND;
      6'b100101: r_alu = A_OR;
      6'b100110: r_alu = A_XOR;
      6'b100111: r_alu = A_NOR;
      6'b101010: r_alu = A_SLT;
      6'b101011: r_alu = A_SLTU;
      6'b000000: r_alu = A_SLL;
      6'b000010: r_alu = A_SRL;
      6'b000011: r_alu = A_SRA;
      6'b000100: r_alu = A_SLLV;
      6'b000110: r_alu = A_SRLV;
      6'b000111: r_alu = A_SRAV;
      default:   r_ok  = 1'b0;
    endcase
  end

  always_comb begin
    i_alu = A_ADD;
    case (Opcode)
      OP_SLTI:  i_alu = A_SLT;
      OP_SLTIU: i_alu = A_SLTU;
      OP_ANDI:  i_alu = A_AND;
      OP_ORI:   i_alu = A_OR;
      OP_XORI:  i_alu = A_XOR;
      OP_LUI:   i_alu = A_LUI;
      default:  i_alu = A_ADD;
    endcase
  end

  always_comb begin
    state_next = state;
    PCWrite    = 1'b0;
    IorD       = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 2'b00;
    MemtoReg   = 2'b00;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b00;
    PCSrc      = 2'b00;
    ALUControl = A_ADD;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        if (rdy) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          state_next = S_DECODE;
        end else if (timed_out) begin
          state_next = S_FAULT;
        end
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        case (Opcode)
          OP_LW, OP_SW:   state_next = S_MEMADR;
          OP_RTYPE:       state_next = is_jr ? S_JUMP : S_RTEXEC;
          OP_BEQ, OP_BNE: state_next = S_BRANCH;
          OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
          OP_ANDI, OP_ORI, OP_XORI, OP_LUI: state_next = S_IEXEC;
          OP_J:           state_next = S_JUMP;
          OP_JAL:         state_next = jal_ok ? S_JUMP : S_FAULT;
          default:        state_next = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
        if (rdy)            state_next = S_MEMWB;
        else if (timed_out) state_next = S_FAULT;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemtoReg   = 2'b01;
        state_next = S_FETCH;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
        if (rdy)            state_next = S_FETCH;
        else if (timed_out) state_next = S_FAULT;
      end
      S_RTEXEC: begin
        ALUSrcA    = 1'b1;
        ALUControl = r_alu;
        state_next = r_ok ? S_RTWB : S_FAULT;
      end
      S_RTWB: begin
        RegWrite   = 1'b1;
        RegDst     = 2'b01;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA    = 1'b1;
        ALUControl = A_SUB;
        PCSrc      = 2'b01;
        PCWrite    = Zero ^ (Opcode == OP_BNE);
        state_next = S_FETCH;
      end
      S_IEXEC: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        ALUControl = i_alu;
        state_next = S_IWB;
      end
      S_IWB: begin
        RegWrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_JUMP: begin
        PCWrite = 1'b1;
        PCSrc   = is_jr ? 2'b11 : 2'b10;
        if (jal_ok && (Opcode == OP_JAL)) begin
          RegWrite = 1'b1;
          RegDst   = 2'b10;
          MemtoReg = 2'b10;
        end
        state_next = S_FETCH;
      end
      S_FAULT: state_next = S_FAULT;
      default: state_next = S_FAULT;
    endcase
    // strobes must not fire in a reset cycle, even mid-access
    if (reset) begin
      PCWrite  = 1'b0;
      MemRead  = 1'b0;
      MemWrite = 1'b0;
      IRWrite  = 1'b0;
      RegWrite = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_FETCH;
      wait_cnt <= 8'd0;
      fault    <= 1'b0;
    end else begin
      state <= state_next;
      if (state_next != state)
        wait_cnt <= 8'd0;
      else if (mem_state && !rdy && (wait_cnt != 8'hFF))
        wait_cnt <= wait_cnt + 8'd1;
      if (state == S_FAULT)
        fault <= 1'b1;
    end
  end

endmodule
